// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one alu_32 between two requesters.
// Each op runs IDLE -> ISSUE -> WAIT -> RESP and returns on one registered response bus.
module alu_share_arbiter #(
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    input  logic [WORD_SIZE-1:0] req0_a,
    input  logic [WORD_SIZE-1:0] req1_a,
    input  logic [WORD_SIZE-1:0] req0_b,
    input  logic [WORD_SIZE-1:0] req1_b,
    input  logic [3:0]           req0_control,
    input  logic [3:0]           req1_control,
    output logic                 req0_ready,
    output logic                 req1_ready,
    output logic                 alu_start,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [3:0]           alu_control,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_cout,
    input  logic                 alu_overflow,
    input  logic                 alu_invalid,
    input  logic                 alu_finished,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [WORD_SIZE-1:0] rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_cout,
    output logic                 rsp_overflow,
    output logic                 rsp_invalid,
    output logic                 rsp_timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   id_q, id_d;
    logic                   alu_start_q, alu_start_d;
    logic [WORD_SIZE-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]             alu_control_q, alu_control_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_id_q, rsp_id_d;
    logic [WORD_SIZE-1:0]   rsp_result_q, rsp_result_d;
    logic                   rsp_zero_q, rsp_zero_d, rsp_cout_q, rsp_cout_d;
    logic                   rsp_overflow_q, rsp_overflow_d, rsp_invalid_q, rsp_invalid_d;
    logic                   rsp_timeout_q, rsp_timeout_d;

    logic any_valid;
    logic grant;

    // With both valid, the requester that did not win last time gets the slot.
    assign any_valid  = req0_valid | req1_valid;
    assign grant      = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    assign req0_ready = (state_q == ST_IDLE) & any_valid & ~grant;
    assign req1_ready = (state_q == ST_IDLE) & any_valid & grant;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        timer_d        = timer_q;
        id_d           = id_q;
        alu_start_d    = 1'b0;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_control_d  = alu_control_q;
        rsp_valid_d    = 1'b0;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_cout_d     = rsp_cout_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_invalid_d  = rsp_invalid_q;
        rsp_timeout_d  = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    id_d          = grant;
                    alu_a_d       = grant ? req1_a : req0_a;
                    alu_b_d       = grant ? req1_b : req0_b;
                    alu_control_d = grant ? req1_control : req0_control;
                    alu_start_d   = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + TW'(1);
                // A finish on the last allowed cycle still counts as a real result.
                if (alu_finished) begin
                    rsp_id_d       = id_q;
                    rsp_result_d   = alu_result;
                    rsp_zero_d     = alu_zero;
                    rsp_cout_d     = alu_cout;
                    rsp_overflow_d = alu_overflow;
                    rsp_invalid_d  = alu_invalid;
                    rsp_timeout_d  = 1'b0;
                    rsp_valid_d    = 1'b1;
                    state_d        = ST_RESP;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_id_d       = id_q;
                    rsp_result_d   = '0;
                    rsp_zero_d     = 1'b0;
                    rsp_cout_d     = 1'b0;
                    rsp_overflow_d = 1'b0;
                    rsp_invalid_d  = 1'b0;
                    rsp_timeout_d  = 1'b1;
                    rsp_valid_d    = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                last_grant_d = rsp_id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= 1'b1;
            timer_q        <= '0;
            id_q           <= 1'b0;
            alu_start_q    <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_control_q  <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_cout_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_invalid_q  <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            timer_q        <= timer_d;
            id_q           <= id_d;
            alu_start_q    <= alu_start_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_control_q  <= alu_control_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_cout_q     <= rsp_cout_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_invalid_q  <= rsp_invalid_d;
            rsp_timeout_q  <= rsp_timeout_d;
        end
    end

    assign alu_start    = alu_start_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_control  = alu_control_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_cout     = rsp_cout_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_invalid  = rsp_invalid_q;
    assign rsp_timeout  = rsp_timeout_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural alu_32 stand-in.
module tb_alu_share_arbiter;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
    logic [3:0]  req0_control = '0, req1_control = '0;
    logic        req0_ready, req1_ready, alu_start;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero, alu_cout, alu_overflow, alu_invalid, alu_finished;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_cout, rsp_overflow, rsp_invalid, rsp_timeout;
    logic [31:0] rsp_result;

    int n_cmp = 0;
    int n_bad = 0;

    alu_share_arbiter #(.WORD_SIZE(32), .TIMEOUT_CYCLES(15)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_control(req0_control), .req1_control(req1_control),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
        .alu_overflow(alu_overflow), .alu_invalid(alu_invalid), .alu_finished(alu_finished),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
        .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout)
    );

    always #5 clock = ~clock;

    // ALU stand-in: finishes finish_delay cycles into WAIT unless never_finish is set.
    int   finish_delay = 0;
    logic never_finish = 1'b0;
    logic busy = 1'b0;
    int   wait_cnt = 0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            wait_cnt <= 0;
        end else if (alu_start) begin
            busy <= 1'b1;
            wait_cnt <= 0;
        end else if (busy) begin
            wait_cnt <= wait_cnt + 1;
            if (alu_finished) busy <= 1'b0;
        end
    end
    assign alu_finished = busy && !never_finish && (wait_cnt == finish_delay);

    logic [32:0] sum33;
    always_comb begin
        sum33        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = '0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        alu_invalid  = 1'b0;
        case (alu_control)
            4'h0: alu_result = alu_a & alu_b;
            4'h1: alu_result = alu_a | alu_b;
            4'hC: alu_result = ~(alu_a | alu_b);
            4'h2: begin
                alu_result   = sum33[31:0];
                alu_cout     = sum33[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
            end
            4'h6: alu_result = alu_a - alu_b;
            default: alu_invalid = 1'b1;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op from requester id, return cycles from accept to alu_start and to rsp_valid.
    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, output int start_at, output int lat);
        int n;
        @(posedge clock); #1;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_control = c; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_control = c; end
        n = 0;
        @(negedge clock);
        while (!(id ? req1_ready : req0_ready) && n < 50) begin @(negedge clock); n++; end
        check_val("ready_seen", 64'(n < 50), 64'd1);
        @(posedge clock); #1;
        req0_valid = 0; req1_valid = 0;
        lat = 0; start_at = -1;
        do begin
            @(negedge clock); lat++;
            if (alu_start && start_at < 0) start_at = lat;
        end while (!rsp_valid && lat < 60);
        $display("op id=%0d a=%0h b=%0h ctl=%0h -> start@%0d rsp@%0d id=%0d res=%0h z%0d c%0d o%0d i%0d t%0d",
                 id, a, b, c, start_at, lat, rsp_id, rsp_result, rsp_zero, rsp_cout,
                 rsp_overflow, rsp_invalid, rsp_timeout);
    endtask

    int st, lat, n, ng, nr, sent0, sent1, g;
    logic [32:0] exp_q[$];
    logic [32:0] e;

    initial begin
        // 1. reset state and idle behaviour
        repeat (2) @(negedge clock);
        check_val("rst_start", 64'(alu_start), 0);
        check_val("rst_rsp_valid", 64'(rsp_valid), 0);
        check_val("rst_alu_a", 64'(alu_a), 0);
        @(posedge clock); #1 reset_n = 1;
        n = 0;
        repeat (4) begin @(negedge clock); if (req0_ready || req1_ready || rsp_valid) n++; end
        check_val("idle_quiet", 64'(n), 0);

        // 2. single ADD from requester 0
        do_op(1'b0, 32'd3, 32'd4, 4'h2, st, lat);
        check_val("t2_start_at", 64'(st), 1);
        check_val("t2_latency", 64'(lat), 3);
        check_val("t2_id", 64'(rsp_id), 0);
        check_val("t2_result", 64'(rsp_result), 64'd7);
        check_val("t2_flags", 64'({rsp_zero, rsp_cout, rsp_overflow, rsp_invalid, rsp_timeout}), 0);
        @(negedge clock);
        check_val("t2_valid_pulse", 64'(rsp_valid), 0);
        check_val("t2_hold", 64'(rsp_result), 64'd7);

        // reset during WAIT: op dropped, outputs cleared asynchronously, req0 wins next
        never_finish = 1;
        @(posedge clock); #1 req0_valid = 1; req0_a = 32'h55; req0_b = 32'h1; req0_control = 4'h2;
        @(posedge clock); #1 req0_valid = 0;
        repeat (3) @(negedge clock);
        #2 reset_n = 0;
        #1;
        check_val("arst_alu_a", 64'(alu_a), 0);
        check_val("arst_rsp_result", 64'(rsp_result), 0);
        check_val("arst_rsp_valid", 64'(rsp_valid), 0);
        never_finish = 0;
        @(posedge clock); #1 reset_n = 1;
        n = 0;
        repeat (20) begin @(negedge clock); if (rsp_valid || alu_start) n++; end
        check_val("arst_no_rsp", 64'(n), 0);
        @(posedge clock); #1 req0_valid = 1; req1_valid = 1;
        @(negedge clock);
        check_val("arst_grant", 64'({req0_ready, req1_ready}), 64'b10);
        #1 req0_valid = 0; req1_valid = 0;

        // 3. both valid continuously, four ops each; expect grant order 0,1,0,1,...
        sent0 = 0; sent1 = 0; ng = 0; nr = 0;
        @(posedge clock); #1;
        req0_valid = 1; req0_a = 32'd10; req0_b = 32'd0; req0_control = 4'h2;
        req1_valid = 1; req1_a = 32'd100; req1_b = 32'd0; req1_control = 4'h2;
        for (int cyc = 0; cyc < 200 && nr < 8; cyc++) begin
            @(negedge clock);
            if (req0_ready && req1_ready) check_val("t3_one_ready", 64'd1, 64'd0);
            if (rsp_valid) begin
                check_val("t3_queue_nonempty", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_val("t3_rsp_id", 64'(rsp_id), 64'(e[32]));
                    check_val("t3_rsp_result", 64'(rsp_result), 64'(e[31:0]));
                    $display("t3 rsp id=%0d res=%0d", rsp_id, rsp_result);
                end
                nr++;
            end
            g = req0_ready ? 0 : (req1_ready ? 1 : -1);
            @(posedge clock); #1;
            if (g >= 0) begin
                check_val("t3_grant_order", 64'(g), 64'(ng % 2));
                ng++;
                if (g == 0) begin
                    exp_q.push_back({1'b0, req0_a + req0_b});
                    sent0++;
                    if (sent0 == 4) req0_valid = 0; else begin req0_a = 10 + sent0; req0_b = sent0; end
                end else begin
                    exp_q.push_back({1'b1, req1_a + req1_b});
                    sent1++;
                    if (sent1 == 4) req1_valid = 0; else begin req1_a = 100 + sent1; req1_b = sent1; end
                end
            end
        end
        check_val("t3_grants", 64'(ng), 8);
        check_val("t3_responses", 64'(nr), 8);
        req0_valid = 0; req1_valid = 0;

        // 4. signed overflow from requester 1
        do_op(1'b1, 32'h7FFF_FFFF, 32'h1, 4'h2, st, lat);
        check_val("t4_id", 64'(rsp_id), 1);
        check_val("t4_result", 64'(rsp_result), 64'h8000_0000);
        check_val("t4_overflow", 64'(rsp_overflow), 1);
        check_val("t4_cout", 64'(rsp_cout), 0);

        // 5. watchdog, then the last-cycle finish that must beat it, then normal service
        never_finish = 1;
        do_op(1'b0, 32'd9, 32'd9, 4'h2, st, lat);
        check_val("t5_latency", 64'(lat), 17);
        check_val("t5_timeout", 64'(rsp_timeout), 1);
        check_val("t5_result", 64'(rsp_result), 0);
        never_finish = 0; finish_delay = 14;
        do_op(1'b0, 32'd9, 32'd9, 4'h2, st, lat);
        check_val("t5_edge_latency", 64'(lat), 17);
        check_val("t5_edge_timeout", 64'(rsp_timeout), 0);
        check_val("t5_edge_result", 64'(rsp_result), 64'd18);
        finish_delay = 0;
        do_op(1'b1, 32'hF0, 32'h0F, 4'h1, st, lat);
        check_val("t5_after_latency", 64'(lat), 3);
        check_val("t5_after_result", 64'(rsp_result), 64'hFF);
        check_val("t5_after_timeout", 64'(rsp_timeout), 0);

        // 6. invalid control is passed through opaquely
        do_op(1'b0, 32'd1, 32'd2, 4'hF, st, lat);
        check_val("t6_invalid", 64'(rsp_invalid), 1);
        check_val("t6_id", 64'(rsp_id), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
